step_sequencer: RTL

//  Paced 8-bit step counter feeding the count-to-address decoder downstream.

---
 rtl/seq_pkg.sv | 15 +
 rtl/tick_div.sv | 37 +++
 rtl/step_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the step sequencer and the count-to-address decoder.
package seq_pkg;

  // Sequencer control states, 2-bit encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Steps per sequence; the decoder maps exactly counts 0..SEQ_COUNT_MAX-1
  localparam int SEQ_COUNT_MAX = 198;

endpackage : seq_pkg

// File: rtl/tick_div.sv
// Prescaler that divides sysclk by DIV; tc flags the last cycle of each period.
module tick_div #(
  parameter int DIV = 5_000_000
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pre_r;

  // Count 0..DIV-1 while enabled; clear has priority, hold when disabled
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      pre_r <= {PW{1'b0}};
    end else if (clr) begin
      pre_r <= {PW{1'b0}};
    end else if (en) begin
      if (pre_r == LAST) begin
        pre_r <= {PW{1'b0}};
      end else begin
        pre_r <= pre_r + PW'(1);
      end
    end else begin
      pre_r <= pre_r;
    end
  end

  // Terminal count reflects the held prescaler value
  assign tc = (pre_r == LAST);

endmodule : tick_div

// File: rtl/step_sequencer.sv
// Paced step counter: FSM, count register and registered status outputs.
module step_sequencer
  import seq_pkg::*;
#(
  parameter int DIV       = 5_000_000,
  parameter int COUNT_MAX = SEQ_COUNT_MAX
) (
  input  logic       sysclk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       stop,
  input  logic       loop,
  output logic [7:0] count,
  output logic       step,
  output logic       running,
  output logic       done
);

  localparam logic [7:0] LAST_COUNT = 8'(COUNT_MAX - 1);

  seq_state_t state_r;
  logic [7:0] count_r;
  logic       step_r;
  logic       running_r;
  logic       done_r;

  logic       idle_like_s;
  logic       pre_clr_s;
  logic       pre_en_s;
  logic       tc_s;

  // Prescaler control: clear on abort or on (re)start, advance only in an unpaused RUN
  always_comb begin
    idle_like_s = (state_r == IDLE) || (state_r == DONE);
    pre_clr_s   = stop || (idle_like_s && start);
    pre_en_s    = (state_r == RUN) && !pause && !stop;
  end

  tick_div #(
    .DIV(DIV)
  ) u_tick_div (
    .sysclk(sysclk),
    .rst_n (rst_n),
    .clr   (pre_clr_s),
    .en    (pre_en_s),
    .tc    (tc_s)
  );

  // Sequencer FSM with count and output registers; stop beats start beats pause beats tick
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      count_r   <= 8'd0;
      step_r    <= 1'b0;
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else if (stop) begin
      state_r   <= IDLE;
      count_r   <= 8'd0;
      step_r    <= 1'b0;
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          step_r  <= 1'b0;
          done_r  <= 1'b0;
          count_r <= 8'd0;
          if (start) begin
            state_r   <= RUN;
            running_r <= 1'b1;
          end else begin
            state_r   <= state_r;
            running_r <= 1'b0;
          end
        end
        RUN: begin
          done_r <= 1'b0;
          if (pause) begin
            // Pausing on a terminal-count cycle swallows the tick until release
            state_r <= PAUSE;
            step_r  <= 1'b0;
          end else if (tc_s) begin
            if (count_r < LAST_COUNT) begin
              count_r <= count_r + 8'd1;
              step_r  <= 1'b1;
            end else if (loop) begin
              count_r <= 8'd0;
              step_r  <= 1'b1;
            end else begin
              // Termination: done pulse replaces the step pulse
              count_r   <= 8'd0;
              state_r   <= DONE;
              done_r    <= 1'b1;
              running_r <= 1'b0;
              step_r    <= 1'b0;
            end
          end else begin
            step_r <= 1'b0;
          end
        end
        PAUSE: begin
          step_r <= 1'b0;
          done_r <= 1'b0;
          if (!pause) begin
            state_r <= RUN;
          end else begin
            state_r <= PAUSE;
          end
        end
        default: begin
          state_r   <= IDLE;
          count_r   <= 8'd0;
          step_r    <= 1'b0;
          running_r <= 1'b0;
          done_r    <= 1'b0;
        end
      endcase
    end
  end

  assign count   = count_r;
  assign step    = step_r;
  assign running = running_r;
  assign done    = done_r;

endmodule : step_sequencer
